lcd_ctl: RTL and testbench



---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_delay_cnt.sv | 43 ++++
 rtl/lcd_ctl.sv | 255 +++++++++++++++++++++++++
 tb/tb_lcd_ctl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style LCD write controller:
//   - lcd_state_e   : controller FSM states
//   - LCD_*         : instruction byte constants
//   - LCD_INIT_ROM  : power-on initialisation sequence (used when the
//                     LCD_CTL_INIT_EN macro is defined)
//   - is_long_cmd() : picks the long execution wait for clear/return-home
//   - max2()        : helper for sizing the delay counter
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_PULSE     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT      = 3'd4,
    ST_INIT_WAIT = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_HOME       = 8'h02;
  localparam logic [7:0] LCD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;

  // Return-home ignores DB0, so 0x03 is also a return-home.
  localparam logic [7:0] LCD_HOME_ALIAS = 8'h03;

  localparam int unsigned LCD_INIT_LEN = 4;

  // 8-bit bus, 2 lines; display on; clear; cursor auto-increment.
  localparam logic [7:0] LCD_INIT_ROM [LCD_INIT_LEN] = '{
    LCD_FUNC_8B2L, LCD_DISP_ON, LCD_CLEAR, LCD_ENTRY_INC
  };

  // Clear and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) &&
           ((data == LCD_CLEAR) || (data == LCD_HOME) || (data == LCD_HOME_ALIAS));
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// -----------------------------------------------------------------------------
// lcd_delay_cnt
// Loadable down counter used for every timed phase of the LCD controller.
// A load takes priority; otherwise the count decrements and saturates at 0.
//   i_clk      : clock
//   i_rst      : asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val on this edge
//   i_load_val : value to load (phase length in cycles)
//   o_value    : current count
//   o_expire   : count equals 1, i.e. the last cycle of the current phase
// -----------------------------------------------------------------------------
module lcd_delay_cnt
  import lcd_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_expire
);

  logic [W-1:0] r_value;

  // Down counter: load, else decrement, never below zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= {W{1'b0}};
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != {W{1'b0}}) begin
      r_value <= r_value - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_value <= r_value;
    end
  end

  assign o_value  = r_value;
  assign o_expire = (r_value == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/lcd_ctl.sv
// -----------------------------------------------------------------------------
// lcd_ctl
// Byte-wide HD44780 write controller. Accepts one instruction/character per
// valid/ready handshake and drives RS/DB setup, an EN pulse, hold and the
// per-instruction execution wait on the panel pins.
//
// Optional feature (macro LCD_CTL_INIT_EN): after reset, wait T_PWR cycles,
// then send the init sequence 0x38, 0x0C, 0x01, 0x06 before accepting user
// commands. Without the macro the controller is idle right after reset.
//
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   cmd_valid_i        : request; must be held until accepted
//   cmd_rs_i           : 0 = instruction, 1 = data
//   cmd_data_i [7:0]   : byte to send
//   cmd_ready_o        : controller can accept on the next edge
//   lcd_on_i/lcd_on_o  : panel power request, registered pass-through
//   lcd_rs_o, lcd_rw_o : RS pin, RW pin (always 0, write only)
//   lcd_en_o           : EN pin
//   lcd_data_o [7:0]   : DB[7:0]
//   busy_o             : inverse of cmd_ready_o (both 0 while in reset)
// -----------------------------------------------------------------------------
module lcd_ctl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned T_PWR   = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  input  logic       lcd_on_i,
  output logic       lcd_on_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o,
  output logic       busy_o
);

  localparam int unsigned T_MAX = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_CMD)),
                                       max2(T_CLR, T_PWR));
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_TWO  = C_ONE + C_ONE;

  lcd_state_e       r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_rs;
  logic             r_en;
  logic             r_on;
  logic [7:0]       r_data;

  logic             w_accept;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic [CNT_W-1:0] w_cnt_value;
  logic             w_cnt_expire;
  logic [CNT_W-1:0] w_wait_val;
  logic             w_ready_nxt;
  logic             w_init_busy;
  logic             w_init_last;

`ifdef LCD_CTL_INIT_EN
  logic             r_init_active;
  logic [1:0]       r_init_idx;

  assign w_init_busy = r_init_active;
  assign w_init_last = (r_init_idx == 2'd3);
`else
  assign w_init_busy = 1'b0;
  assign w_init_last = 1'b0;
`endif

  lcd_delay_cnt #(
    .W (CNT_W)
  ) u_delay_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_value    (w_cnt_value),
    .o_expire   (w_cnt_expire)
  );

  // Counter reload and next-ready decisions shared with the FSM below.
  // Ready is raised for the last WAIT cycle so a held request is taken on
  // the very edge the wait ends, leaving no extra idle cycle between bytes.
  always_comb begin
    w_accept       = cmd_valid_i & r_ready;
    w_wait_val     = is_long_cmd(r_rs, r_data) ? CNT_W'(T_CLR) : CNT_W'(T_CMD);
    w_cnt_load     = 1'b0;
    w_cnt_load_val = CNT_W'(T_SETUP);
    w_ready_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_load     = w_accept;
        w_cnt_load_val = CNT_W'(T_SETUP);
        w_ready_nxt    = ~w_accept;
      end
      ST_SETUP: begin
        w_cnt_load     = w_cnt_expire;
        w_cnt_load_val = CNT_W'(T_EN);
      end
      ST_PULSE: begin
        w_cnt_load     = w_cnt_expire;
        w_cnt_load_val = CNT_W'(T_HOLD);
      end
      ST_HOLD: begin
        w_cnt_load     = w_cnt_expire;
        w_cnt_load_val = w_wait_val;
        // A one-cycle wait is already the final wait cycle.
        w_ready_nxt    = w_cnt_expire & ~w_init_busy & (w_wait_val == C_ONE);
      end
      ST_WAIT: begin
        w_cnt_load_val = CNT_W'(T_SETUP);
        if (w_cnt_expire) begin
          if (w_init_busy) begin
            w_cnt_load  = ~w_init_last;
            w_ready_nxt = w_init_last;
          end else begin
            w_cnt_load  = w_accept;
            w_ready_nxt = ~w_accept;
          end
        end else begin
          w_cnt_load  = 1'b0;
          w_ready_nxt = ~w_init_busy & (w_cnt_value == C_TWO);
        end
      end
`ifdef LCD_CTL_INIT_EN
      ST_INIT_WAIT: begin
        // Counter comes out of reset at zero: first edge starts the power-on delay.
        if (w_cnt_value == C_ZERO) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CNT_W'(T_PWR);
        end else if (w_cnt_expire) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CNT_W'(T_SETUP);
        end else begin
          w_cnt_load     = 1'b0;
        end
      end
`endif
      default: begin
        w_cnt_load  = 1'b0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Main FSM with registered pin outputs; reset drops EN immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef LCD_CTL_INIT_EN
      r_state       <= ST_INIT_WAIT;
      r_init_active <= 1'b1;
      r_init_idx    <= 2'd0;
`else
      r_state       <= ST_IDLE;
`endif
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_on    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_on    <= lcd_on_i;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rs    <= cmd_rs_i;
            r_data  <= cmd_data_i;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_cnt_expire) begin
            r_en    <= 1'b1;
            r_state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (w_cnt_expire) begin
            r_en    <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_cnt_expire) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_cnt_expire) begin
            if (w_init_busy) begin
`ifdef LCD_CTL_INIT_EN
              if (w_init_last) begin
                r_init_active <= 1'b0;
                r_state       <= ST_IDLE;
              end else begin
                r_init_idx <= r_init_idx + 2'd1;
                r_rs       <= 1'b0;
                r_data     <= LCD_INIT_ROM[r_init_idx + 2'd1];
                r_state    <= ST_SETUP;
              end
`endif
            end else if (w_accept) begin
              r_rs    <= cmd_rs_i;
              r_data  <= cmd_data_i;
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
`ifdef LCD_CTL_INIT_EN
        ST_INIT_WAIT: begin
          if (w_cnt_expire) begin
            r_init_idx <= 2'd0;
            r_rs       <= 1'b0;
            r_data     <= LCD_INIT_ROM[0];
            r_state    <= ST_SETUP;
          end
        end
`endif
        default: begin
          r_en    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign lcd_on_o    = r_on;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_data_o  = r_data;

endmodule

// File: tb/tb_lcd_ctl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctl: self-checking bench for lcd_ctl (small timing parameters).
// "Ready edge" below is the first clock edge, counted from the accepting edge
// E0, at which cmd_ready_o is sampled high again.
// -----------------------------------------------------------------------------
module tb_lcd_ctl;

  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 1;
  localparam int P_CMD   = 10;
  localparam int P_CLR   = 40;
  localparam int P_PWR   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       lcd_on_in;
  logic       lcd_on_out;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_rdy;
  } vec_t;

  vec_t vecs [8];

  lcd_ctl #(
    .T_SETUP (P_SETUP),
    .T_EN    (P_EN),
    .T_HOLD  (P_HOLD),
    .T_CMD   (P_CMD),
    .T_CLR   (P_CLR),
    .T_PWR   (P_PWR)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_rs_i    (cmd_rs),
    .cmd_data_i  (cmd_data),
    .cmd_ready_o (cmd_ready),
    .lcd_on_i    (lcd_on_in),
    .lcd_on_o    (lcd_on_out),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_en_o    (lcd_en),
    .lcd_data_o  (lcd_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: total busy time is setup + pulse + hold + execution wait.
  function automatic int ref_ready_edge(input logic rs, input logic [7:0] data);
    int w;
    w = ((rs == 1'b0) && (data >= 8'd1) && (data <= 8'd3)) ? P_CLR : P_CMD;
    return P_SETUP + P_EN + P_HOLD + w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while ((cmd_ready !== 1'b1) && (k < 400)) begin
      tick();
      k++;
    end
    if (k >= 400) check(name, 32'd0, 32'd1);
  endtask

  // One full transfer; returns EN rise offset, EN width, ready edge, pins at E0+1.
  task automatic xfer(input logic rs, input logic [7:0] data,
                      output int en_rise, output int en_len, output int rdy_edge,
                      output logic rs_seen, output logic [7:0] d_seen);
    wait_ready("xfer_idle_timeout");
    cmd_rs    = rs;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_rs    = ~rs;
    cmd_data  = ~data;
    en_rise   = -1;
    en_len    = 0;
    rdy_edge  = -1;
    rs_seen   = 1'b0;
    d_seen    = 8'h00;
    for (int k = 1; (k <= 200) && (rdy_edge < 0); k++) begin
      tick();
      if (k == 1) begin
        rs_seen = lcd_rs;
        d_seen  = lcd_data;
      end
      if (lcd_en === 1'b1) begin
        if (en_rise < 0) en_rise = k;
        en_len++;
      end
      if (cmd_ready === 1'b1) rdy_edge = k + 1;
    end
  endtask

  task automatic run_xfer_checks(input string tag, input logic rs, input logic [7:0] data,
                                 input int exp_rdy);
    int en_rise, en_len, rdy_edge;
    logic rs_seen;
    logic [7:0] d_seen;
    xfer(rs, data, en_rise, en_len, rdy_edge, rs_seen, d_seen);
    check({tag, "_rs"},       {31'd0, rs_seen}, {31'd0, rs});
    check({tag, "_data"},     {24'd0, d_seen},  {24'd0, data});
    check({tag, "_en_rise"},  en_rise,  P_SETUP);
    check({tag, "_en_len"},   en_len,   P_EN);
    check({tag, "_rdy_edge"}, rdy_edge, exp_rdy);
    check({tag, "_rw"},       {31'd0, lcd_rw}, 32'd0);
  endtask

`ifdef LCD_CTL_INIT_EN
  // Power-on init: four instruction pulses, no user command taken meanwhile.
  task automatic init_check(input string tag);
    int         rise [4];
    logic [7:0] dat  [4];
    logic       rsv  [4];
    int         n_rise, early_bad, rdy_k, prev_en;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h38; exp_d[1] = 8'h0C; exp_d[2] = 8'h01; exp_d[3] = 8'h06;
    n_rise = 0; early_bad = 0; rdy_k = -1; prev_en = 0;
    cmd_rs = 1'b1; cmd_data = 8'hAA; cmd_valid = 1'b1;
    for (int k = 1; (k <= 600) && (rdy_k < 0); k++) begin
      tick();
      if ((k <= P_PWR) && (cmd_ready !== 1'b0)) early_bad++;
      if ((lcd_en === 1'b1) && (prev_en == 0)) begin
        if (n_rise < 4) begin
          rise[n_rise] = k; dat[n_rise] = lcd_data; rsv[n_rise] = lcd_rs;
        end
        n_rise++;
      end
      prev_en = (lcd_en === 1'b1) ? 1 : 0;
      if (cmd_ready === 1'b1) begin
        rdy_k     = k;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check({tag, "_ready_low_pwr"}, early_bad, 0);
    check({tag, "_n_pulses"}, n_rise, 4);
    if (n_rise == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_data%0d", tag, i), {24'd0, dat[i]}, {24'd0, exp_d[i]});
        check($sformatf("%s_rs%0d", tag, i), {31'd0, rsv[i]}, 32'd0);
      end
      check({tag, "_gap01"}, rise[1] - rise[0], P_SETUP + P_EN + P_HOLD + P_CMD);
      check({tag, "_gap12"}, rise[2] - rise[1], P_SETUP + P_EN + P_HOLD + P_CMD);
      check({tag, "_gap23"}, rise[3] - rise[2], P_SETUP + P_EN + P_HOLD + P_CLR);
      check({tag, "_ready_after"}, rdy_k, rise[3] + P_EN + P_HOLD + P_CMD);
    end
    check({tag, "_no_user_cmd"}, {31'd0, (lcd_data == 8'hAA)}, 32'd0);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_rise, en_len, rdy_edge, rises, bad, prev_en, acc_pending, acc_edge;
    int rise1, rise2;
    logic rs_seen, rv, prev_on;
    logic [7:0] d_seen, dv, d2;

    vecs[0] = '{1'b1, 8'h41, 17};
    vecs[1] = '{1'b0, 8'h01, 47};
    vecs[2] = '{1'b0, 8'h02, 47};
    vecs[3] = '{1'b0, 8'h38, 17};
    vecs[4] = '{1'b0, 8'h03, 47};
    vecs[5] = '{1'b0, 8'h04, 17};
    vecs[6] = '{1'b1, 8'h01, 17};
    vecs[7] = '{1'b0, 8'h00, 17};

    // Reset state
    rst = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00; lcd_on_in = 1'b1;
    #2;
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_en",    {31'd0, lcd_en},    32'd0);
    check("rst_rs",    {31'd0, lcd_rs},    32'd0);
    check("rst_data",  {24'd0, lcd_data},  32'd0);
    check("rst_on",    {31'd0, lcd_on_out}, 32'd0);
    tick();
    check("rst_on_held", {31'd0, lcd_on_out}, 32'd0);
    rst = 1'b0;
`ifdef LCD_CTL_INIT_EN
    init_check("init");
`else
    tick();
    check("rst_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy_after",  {31'd0, busy},      32'd0);
`endif

    // lcd_on pass-through is a one-cycle delay
    for (int i = 0; i < 6; i++) begin
      prev_on   = lcd_on_in;
      lcd_on_in = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("lcd_on_%0d", i), {31'd0, lcd_on_out}, {31'd0, lcd_on_in});
      check($sformatf("lcd_on_stale_%0d", i), {31'd0, (lcd_on_out !== lcd_on_in) && (lcd_on_out === prev_on)}, 32'd0);
    end

    // Table of directed transfers
    for (int i = 0; i < 8; i++) begin
      run_xfer_checks($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].exp_rdy);
    end

    // Randomized transfers against the reference latency
    for (int i = 0; i < 16; i++) begin
      rv = 1'($urandom_range(0, 1));
      dv = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      run_xfer_checks($sformatf("rnd%0d", i), rv, dv, ref_ready_edge(rv, dv));
    end

    // Busy rejection: request at E0+5 is ignored
    wait_ready("busy_idle_timeout");
    cmd_rs = 1'b1; cmd_data = 8'h41; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rises = 0; bad = 0; prev_en = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 8'h55;
      end
      tick();
      if (k == 5) cmd_valid = 1'b0;
      if ((lcd_en === 1'b1) && (prev_en == 0)) rises++;
      prev_en = (lcd_en === 1'b1) ? 1 : 0;
      if (lcd_data !== 8'h41) bad++;
    end
    check("busy_en_pulses", rises, 1);
    check("busy_data_kept", bad, 0);
    check("busy_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Back-to-back: second byte taken on the edge the first wait ends
    wait_ready("b2b_idle_timeout");
    cmd_rs = 1'b1; cmd_data = 8'h48; cmd_valid = 1'b1;
    tick();
    cmd_data = 8'h49;
    rise1 = -1; rise2 = -1; rises = 0; prev_en = 0; acc_pending = 0; acc_edge = -1; d2 = 8'h00;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (acc_pending != 0) begin
        cmd_valid = 1'b0;
        acc_edge  = k;
      end
      acc_pending = ((cmd_valid === 1'b1) && (cmd_ready === 1'b1)) ? 1 : 0;
      if ((lcd_en === 1'b1) && (prev_en == 0)) begin
        rises++;
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) begin
          rise2 = k;
          d2    = lcd_data;
        end
      end
      prev_en = (lcd_en === 1'b1) ? 1 : 0;
    end
    cmd_valid = 1'b0;
    check("b2b_accept_edge", acc_edge, 17);
    check("b2b_rise1", rise1, P_SETUP);
    check("b2b_spacing", rise2 - rise1, 17);
    check("b2b_data2", {24'd0, d2}, 32'h49);
    check("b2b_pulses", rises, 2);

    // Reset in the middle of the EN pulse
    wait_ready("rstmid_idle_timeout");
    cmd_rs = 1'b1; cmd_data = 8'h5A; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("rstmid_en_before", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_en",    {31'd0, lcd_en},   32'd0);
    check("rstmid_rs",    {31'd0, lcd_rs},   32'd0);
    check("rstmid_data",  {24'd0, lcd_data}, 32'd0);
    check("rstmid_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    rst = 1'b0;
`ifdef LCD_CTL_INIT_EN
    init_check("reinit");
`else
    tick();
    check("rstmid_ready_after", {31'd0, cmd_ready}, 32'd1);
    rises = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (lcd_en === 1'b1) rises++;
    end
    check("rstmid_no_pulse", rises, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
